// File: rtl/multi_channel_timer.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_timer
// Brief    : Bus-mapped bank of prescaled periodic/one-shot timers with shared IRQ.
// Revision : 1.0
// ============================================================================
module multi_channel_timer #(
    parameter int             BITS     = 32,
    parameter int             CHANNELS = 4,
    parameter logic [BITS-1:0] BASE    = BITS'(32'hFFFF0200),
    parameter int             PRESCALE = 50000
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [BITS-1:0] ADDRBUS,
    inout  wire  [BITS-1:0] DATABUS,
    input  logic            WE,
    output logic            IRQ
);

    localparam int              PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [BITS-1:0]  STAT_OFS = BITS'(16 * CHANNELS);

    logic [PRE_W-1:0] pre;
    logic             tick;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    assign tick = (pre == PRE_LAST);

    logic [BITS-1:0] offset;
    logic [1:0]      reg_sel;
    logic            aligned;
    logic            stat_hit;

    assign offset   = ADDRBUS - BASE;
    assign reg_sel  = offset[3:2];
    assign aligned  = (offset[1:0] == 2'b00);
    assign stat_hit = (offset == STAT_OFS);

    logic [CHANNELS-1:0]           ch_hit;
    logic [CHANNELS-1:0]           ready_v;
    logic [CHANNELS-1:0]           ie_v;
    logic [CHANNELS-1:0][BITS-1:0] cnt_v;
    logic [CHANNELS-1:0][BITS-1:0] lim_v;
    logic [CHANNELS-1:0][BITS-1:0] ctrl_v;

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            logic [BITS-1:0] cnt;
            logic [BITS-1:0] lim;
            logic            ready;
            logic            overrun;
            logic            mode;
            logic            run;
            logic            ie;
            logic            wr_cnt;
            logic            wr_lim;
            logic            wr_ctrl;
            logic            limit_hit;

            assign ch_hit[c]  = aligned && (offset[BITS-1:4] == (BITS-4)'(c));
            assign wr_cnt     = WE && ch_hit[c] && (reg_sel == 2'd0);
            assign wr_lim     = WE && ch_hit[c] && (reg_sel == 2'd1);
            assign wr_ctrl    = WE && ch_hit[c] && (reg_sel == 2'd2);
            assign limit_hit  = (lim != '0) && (cnt >= lim - 1'b1);

            // Later assignments deliberately override the tick update on ready/overrun/run.
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    cnt     <= '0;
                    lim     <= '0;
                    ready   <= 1'b0;
                    overrun <= 1'b0;
                    mode    <= 1'b0;
                    run     <= 1'b1;
                    ie      <= 1'b1;
                end else begin
                    if (wr_cnt) begin
                        cnt     <= DATABUS;
                        ready   <= 1'b0;
                        overrun <= 1'b0;
                    end else if (tick && run) begin
                        if (limit_hit) begin
                            cnt     <= '0;
                            ready   <= 1'b1;
                            overrun <= ready;
                            if (mode) begin
                                run <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    if (wr_lim) begin
                        lim     <= DATABUS;
                        ready   <= 1'b0;
                        overrun <= 1'b0;
                    end
                    if (wr_ctrl) begin
                        ready   <= DATABUS[0];
                        overrun <= overrun & DATABUS[1];
                        mode    <= DATABUS[2];
                        run     <= DATABUS[3];
                        ie      <= DATABUS[4];
                    end
                end
            end

            assign cnt_v[c]   = cnt;
            assign lim_v[c]   = lim;
            assign ctrl_v[c]  = {{(BITS-5){1'b0}}, ie, run, mode, overrun, ready};
            assign ready_v[c] = ready;
            assign ie_v[c]    = ie;
        end
    endgenerate

    logic [BITS-1:0] rdata;
    logic            mapped;

    always_comb begin
        rdata  = '0;
        mapped = 1'b0;
        if (stat_hit) begin
            mapped                = 1'b1;
            rdata[CHANNELS-1:0] = ready_v;
        end
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_hit[c]) begin
                case (reg_sel)
                    2'd0: begin
                        mapped = 1'b1;
                        rdata  = cnt_v[c];
                    end
                    2'd1: begin
                        mapped = 1'b1;
                        rdata  = lim_v[c];
                    end
                    2'd2: begin
                        mapped = 1'b1;
                        rdata  = ctrl_v[c];
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign DATABUS = (!RESET && !WE && mapped) ? rdata : {BITS{1'bz}};
    assign IRQ     = |(ready_v & ie_v);

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_channel_timer
// Brief    : Directed + random bench for multi_channel_timer against a cycle model.
// Revision : 1.0
// ============================================================================
module tb_multi_channel_timer;

    localparam logic [31:0] BASE = 32'hFFFF0200;
    localparam int          P    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic        drv_en;
    logic [31:0] addr;
    logic [31:0] drv_data;
    wire  [31:0] databus;
    wire         irq;

    // Undriven bus reads as all ones, which is how high-Z is recognised.
    assign databus = drv_en ? drv_data : 32'hzzzzzzzz;
    pullup p_bus (databus);

    always #5 clk = ~clk;

    multi_channel_timer #(
        .BITS     (32),
        .CHANNELS (4),
        .BASE     (BASE),
        .PRESCALE (P)
    ) dut (
        .CLK     (clk),
        .RESET   (rst),
        .ADDRBUS (addr),
        .DATABUS (databus),
        .WE      (we),
        .IRQ     (irq)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_rd;
    logic        last_irq;

    int          m_pre;
    bit   [31:0] m_cnt [4];
    bit   [31:0] m_lim [4];
    bit          m_rdy [4];
    bit          m_ovr [4];
    bit          m_mode[4];
    bit          m_run [4];
    bit          m_ie  [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pre = 0;
        for (int c = 0; c < 4; c++) begin
            m_cnt[c] = 0; m_lim[c] = 0; m_rdy[c] = 0; m_ovr[c] = 0;
            m_mode[c] = 0; m_run[c] = 1; m_ie[c] = 1;
        end
    endtask

    function automatic logic m_irq();
        logic r;
        r = 1'b0;
        for (int c = 0; c < 4; c++) r = r | (m_rdy[c] & m_ie[c]);
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] off;
        int          c;
        logic [31:0] r;
        off = a - BASE;
        c   = int'(off[5:4]);
        r   = 32'hFFFF_FFFF;
        if (off == 32'd64) begin
            r = {28'd0, m_rdy[3], m_rdy[2], m_rdy[1], m_rdy[0]};
        end else if (off < 32'd64 && off[1:0] == 2'b00) begin
            case (off[3:2])
                2'd0: r = m_cnt[c];
                2'd1: r = m_lim[c];
                2'd2: r = {27'd0, m_ie[c], m_run[c], m_mode[c], m_ovr[c], m_rdy[c]};
                default: r = 32'hFFFF_FFFF;
            endcase
        end
        return r;
    endfunction

    // One clock edge of the programmer-visible behaviour.
    task automatic m_step(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        bit          tick, hit, old_rdy, old_ovr;
        int          ch, rg;
        tick  = (m_pre == P - 1);
        m_pre = tick ? 0 : m_pre + 1;
        off   = a - BASE;
        hit   = w && (off < 32'd64) && (off[1:0] == 2'b00);
        ch    = int'(off[5:4]);
        rg    = int'(off[3:2]);
        for (int c = 0; c < 4; c++) begin
            old_rdy = m_rdy[c];
            old_ovr = m_ovr[c];
            if (hit && ch == c && rg == 0) begin
                m_cnt[c] = d; m_rdy[c] = 0; m_ovr[c] = 0;
            end else if (tick && m_run[c]) begin
                if (m_lim[c] != 0 && m_cnt[c] >= m_lim[c] - 1) begin
                    m_cnt[c] = 0; m_rdy[c] = 1; m_ovr[c] = old_rdy;
                    if (m_mode[c]) m_run[c] = 0;
                end else begin
                    m_cnt[c] = m_cnt[c] + 1;
                end
            end
            if (hit && ch == c && rg == 1) begin
                m_lim[c] = d; m_rdy[c] = 0; m_ovr[c] = 0;
            end
            if (hit && ch == c && rg == 2) begin
                m_rdy[c] = d[0]; m_ovr[c] = old_ovr & d[1];
                m_mode[c] = d[2]; m_run[c] = d[3]; m_ie[c] = d[4];
            end
        end
    endtask

    // Called just after a falling edge; spans one full clock.
    task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d);
        we = w; addr = a; drv_en = w; drv_data = d;
        #1;
        last_irq = irq;
        chk("irq", {31'd0, irq}, {31'd0, m_irq()});
        if (!w) begin
            last_rd = databus;
            chk("rd", databus, m_read(a));
        end
        @(posedge clk);
        m_step(w, a, d);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          found;
        int          sel;
        logic [31:0] a;
        logic [31:0] d;
        logic        w;

        rst = 1'b1; we = 1'b0; drv_en = 1'b0; addr = BASE + 32'h8; drv_data = '0;
        m_reset();
        #12;
        chk("rst_bus_z", databus, 32'hFFFF_FFFF);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset values and free-running count on channel 0
        cyc(0, BASE + 32'h8, 0);   chk("t1_ctrl0", last_rd, 32'h18);
        cyc(0, BASE + 32'h40, 0);  chk("t1_stat", last_rd, 32'h0);
        repeat (10) cyc(0, BASE, 0);

        // Periodic channel 1
        cyc(1, BASE + 32'h14, 3);
        cyc(1, BASE + 32'h10, 0);
        repeat (14) cyc(0, BASE + 32'h40, 0);
        chk("t2_stat", last_rd, 32'h2);
        chk("t2_irq", {31'd0, irq}, 32'd1);
        cyc(1, BASE + 32'h18, 32'h18);
        cyc(0, BASE + 32'h18, 0);
        chk("t2_irq_clr", {31'd0, last_irq}, 32'd0);

        // One-shot channel 2
        cyc(1, BASE + 32'h24, 2);
        cyc(1, BASE + 32'h20, 0);
        cyc(1, BASE + 32'h28, 32'h1C);
        repeat (12) cyc(0, BASE + 32'h28, 0);
        repeat (40) cyc(0, BASE + 32'h20, 0);
        chk("t3_cnt", last_rd, 32'h0);
        cyc(0, BASE + 32'h28, 0);  chk("t3_ctrl", last_rd, 32'h15);

        // Overrun on channel 3
        cyc(1, BASE + 32'h34, 2);
        cyc(1, BASE + 32'h30, 0);
        repeat (24) cyc(0, BASE + 32'h38, 0);
        chk("t4_ovr", last_rd, 32'h1B);
        cyc(1, BASE + 32'h38, 32'h1A);
        cyc(0, BASE + 32'h38, 0);  chk("t4_keep", last_rd, 32'h1A);
        cyc(1, BASE + 32'h38, 32'h18);
        cyc(0, BASE + 32'h38, 0);  chk("t4_clr", last_rd, 32'h18);

        // CTRL write landing on a channel 0 limit event
        cyc(1, BASE + 32'h4, 2);
        cyc(1, BASE, 0);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (m_pre == P - 1 && m_run[0] && m_lim[0] != 0 && m_cnt[0] >= m_lim[0] - 1)
                found = 1;
            else
                cyc(0, BASE + 32'h8, 0);
        end
        chk("t5_event_found", {31'd0, found}, 32'd1);
        cyc(1, BASE + 32'h8, 32'h18);
        cyc(0, BASE + 32'h8, 0);   chk("t5_ctrl", last_rd, 32'h18);
        chk("t5_irq", {31'd0, last_irq}, {31'd0, m_rdy[1] & m_ie[1] | m_rdy[2] & m_ie[2] | m_rdy[3] & m_ie[3]});
        cyc(0, BASE, 0);           chk("t5_cnt", last_rd, 32'h0);

        // Asynchronous reset while channel 1 holds cnt=2, ready=1
        cyc(1, BASE + 32'h18, 32'h10);
        cyc(1, BASE + 32'h10, 2);
        cyc(1, BASE + 32'h18, 32'h11);
        cyc(0, BASE + 32'h10, 0);  chk("t6_cnt_pre", last_rd, 32'h2);
        chk("t6_irq_pre", {31'd0, last_irq}, 32'd1);
        addr = BASE + 32'h10; we = 1'b0; drv_en = 1'b0;
        #2 rst = 1'b1;
        m_reset();
        #1;
        chk("t6_irq_rst", {31'd0, irq}, 32'd0);
        chk("t6_bus_rst", databus, 32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b0;
        cyc(0, BASE + 32'h18, 0);  chk("t6_ctrl1", last_rd, 32'h18);
        cyc(0, BASE + 32'h10, 0);  chk("t6_cnt1", last_rd, 32'h0);
        cyc(0, BASE + 32'h0C, 0);  chk("t6_unmapped", last_rd, 32'hFFFF_FFFF);
        cyc(0, BASE + 32'h44, 0);  chk("t6_beyond", last_rd, 32'hFFFF_FFFF);

        // Random register traffic
        repeat (400) begin
            sel = $urandom_range(0, 19);
            if (sel == 0)      a = BASE + 32'h40;
            else if (sel == 1) a = BASE + 32'h44;
            else               a = BASE + 32'($urandom_range(0, 3) * 16 + $urandom_range(0, 3) * 4);
            w = ($urandom_range(0, 3) == 0);
            case (a[3:2])
                2'd0, 2'd1: d = 32'($urandom_range(0, 5));
                2'd2:       d = $urandom | 32'h0000_0008;
                default:    d = $urandom;
            endcase
            cyc(w, a, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
